// File: rtl/accum_cpu.sv
// rtl/accum_cpu.sv - multi-cycle accumulator CPU with handshaked single-port memory
//
// Purpose: fetch/decode/execute accumulator machine.
// Instruction word: opcode in the top three bits, operand address in the low ADDR_W bits.
// Ports:
//   clock, reset          - single clock, asynchronous active-high reset
//   run                   - start/resume request, honoured only in IDLE or HALT
//   mem_addr/mem_rd/mem_wr/mem_wdata/mem_rdata/mem_ready
//                         - memory port; a request holds until mem_ready is seen on an edge
//   acc, pc, carry, zero  - architectural state (zero is combinational A == 0)
//   halted, retire        - HALT indicator and one-cycle instruction-complete pulse

module accum_cpu #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 5,
    parameter int RESET_PC = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] acc,
    output logic [ADDR_W-1:0] pc,
    output logic              carry,
    output logic              zero,
    output logic              halted,
    output logic              retire
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC_RD, S_EXEC_WR, S_HALT
    } state_t;

    localparam logic [2:0] OP_LDA = 3'b000;
    localparam logic [2:0] OP_STA = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_JMP = 3'b101;
    localparam logic [2:0] OP_JZ  = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    localparam logic [ADDR_W-1:0] RESET_PC_V = ADDR_W'(RESET_PC);

    state_t              state_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [DATA_W-1:0]   acc_q;
    logic [DATA_W-1:0]   ir_q;
    logic                carry_q;
    logic                mem_rd_q;
    logic                mem_wr_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic                retire_q;
    logic                halted_q;

    logic [2:0]          opcode;
    logic [ADDR_W-1:0]   ir_addr;
    logic [ADDR_W-1:0]   pc_inc;
    logic [ADDR_W-1:0]   jz_target_d;
    logic [DATA_W:0]     sum;
    logic [DATA_W:0]     diff;
    logic [DATA_W-1:0]   acc_d;
    logic                carry_d;

    // Decode fields and the ALU result for the operand currently on mem_rdata.
    always_comb begin
        opcode      = ir_q[DATA_W-1 -: 3];
        ir_addr     = ir_q[ADDR_W-1:0];
        pc_inc      = pc_q + ADDR_W'(1);
        jz_target_d = (acc_q == '0) ? ir_addr : pc_q;
        sum         = {1'b0, acc_q} + {1'b0, mem_rdata};
        // The extra top bit of the widened subtraction is set exactly when A < M.
        diff        = {1'b0, acc_q} - {1'b0, mem_rdata};
        acc_d       = acc_q;
        carry_d     = carry_q;
        case (opcode)
            OP_LDA: acc_d = mem_rdata;
            OP_ADD: begin
                acc_d   = sum[DATA_W-1:0];
                carry_d = sum[DATA_W];
            end
            OP_SUB: begin
                acc_d   = diff[DATA_W-1:0];
                carry_d = diff[DATA_W];
            end
            OP_AND: acc_d = acc_q & mem_rdata;
            default: ;
        endcase
    end

    // Every transition into FETCH raises mem_rd with the fetch address on the same
    // edge, so the memory request is a registered output with no combinational path.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC_V;
            acc_q      <= '0;
            ir_q       <= '0;
            carry_q    <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= RESET_PC_V;
            retire_q   <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            retire_q <= 1'b0;
            case (state_q)
                S_IDLE, S_HALT: begin
                    if (run) begin
                        state_q    <= S_FETCH;
                        mem_rd_q   <= 1'b1;
                        mem_addr_q <= pc_q;
                        halted_q   <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (mem_ready) begin
                        ir_q     <= mem_rdata;
                        pc_q     <= pc_inc;
                        mem_rd_q <= 1'b0;
                        state_q  <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    case (opcode)
                        OP_STA: begin
                            state_q    <= S_EXEC_WR;
                            mem_wr_q   <= 1'b1;
                            mem_addr_q <= ir_addr;
                        end
                        OP_JMP: begin
                            pc_q       <= ir_addr;
                            mem_addr_q <= ir_addr;
                            mem_rd_q   <= 1'b1;
                            state_q    <= S_FETCH;
                            retire_q   <= 1'b1;
                        end
                        OP_JZ: begin
                            pc_q       <= jz_target_d;
                            mem_addr_q <= jz_target_d;
                            mem_rd_q   <= 1'b1;
                            state_q    <= S_FETCH;
                            retire_q   <= 1'b1;
                        end
                        OP_HLT: begin
                            state_q  <= S_HALT;
                            halted_q <= 1'b1;
                            retire_q <= 1'b1;
                        end
                        default: begin
                            state_q    <= S_EXEC_RD;
                            mem_rd_q   <= 1'b1;
                            mem_addr_q <= ir_addr;
                        end
                    endcase
                end
                S_EXEC_RD: begin
                    // mem_rd stays high: the next fetch request follows back-to-back.
                    if (mem_ready) begin
                        acc_q      <= acc_d;
                        carry_q    <= carry_d;
                        mem_addr_q <= pc_q;
                        state_q    <= S_FETCH;
                        retire_q   <= 1'b1;
                    end
                end
                S_EXEC_WR: begin
                    if (mem_ready) begin
                        mem_wr_q   <= 1'b0;
                        mem_rd_q   <= 1'b1;
                        mem_addr_q <= pc_q;
                        state_q    <= S_FETCH;
                        retire_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    mem_rd_q <= 1'b0;
                    mem_wr_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_wdata = acc_q;
    assign acc       = acc_q;
    assign pc        = pc_q;
    assign carry     = carry_q;
    assign zero      = (acc_q == '0);
    assign halted    = halted_q;
    assign retire    = retire_q;

endmodule
